// File: rtl/dekatron_stepper.sv
// Dekatron guide-phase stepper: moves the glow one cathode at a time to a one-hot target.
// Optional bidirectional shortest-path stepping: define DEKATRON_STEPPER_SHORTEST_PATH_EN.
module dekatron_stepper #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned CNT_W     = $clog2(PULSE_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       request,
    input  logic [9:0] target,
    output logic       guide1,
    output logic       guide2,
    output logic [9:0] position,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {IDLE, PH_A, PH_B, FIN} state_t;

    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(PULSE_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [9:0]       tgt_q, tgt_d;
    logic [9:0]       pos_d;
    logic             guide1_d, guide2_d, busy_d, done_d, error_d;

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

`ifdef DEKATRON_STEPPER_SHORTEST_PATH_EN
    logic       back_q, back_d;
    logic [3:0] p_idx, q_idx;
    logic [4:0] dist;

    function automatic logic [3:0] index_of(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Forward distance mod 10; anything beyond half a turn is shorter backward.
    always_comb begin
        p_idx = index_of(position);
        q_idx = index_of(target);
        dist  = (q_idx >= p_idx) ? 5'(q_idx - p_idx) : 5'(5'(q_idx) + 5'd10 - 5'(p_idx));
    end
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tgt_d   = tgt_q;
        pos_d   = position;
        error_d = 1'b0;
`ifdef DEKATRON_STEPPER_SHORTEST_PATH_EN
        back_d  = back_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                timer_d = '0;
                if (request) begin
                    tgt_d = target;
                    if (!is_onehot(target)) begin
                        error_d = 1'b1;
                    end else if (target == position) begin
                        state_d = FIN;
                    end else begin
                        state_d = PH_A;
                        timer_d = TIMER_LOAD;
`ifdef DEKATRON_STEPPER_SHORTEST_PATH_EN
                        back_d  = (dist > 5'd5);
`endif
                    end
                end
            end
            PH_A: begin
                if (timer_q == '0) begin
                    state_d = PH_B;
                    timer_d = TIMER_LOAD;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            PH_B: begin
                if (timer_q == '0) begin
`ifdef DEKATRON_STEPPER_SHORTEST_PATH_EN
                    pos_d = back_q ? {position[0], position[9:1]} : {position[8:0], position[9]};
`else
                    pos_d = {position[8:0], position[9]};
`endif
                    if (pos_d == tgt_q) begin
                        state_d = FIN;
                        timer_d = '0;
                    end else begin
                        state_d = PH_A;
                        timer_d = TIMER_LOAD;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the upcoming state so they align with it.
        busy_d = (state_d == PH_A) || (state_d == PH_B);
        done_d = (state_d == FIN);
`ifdef DEKATRON_STEPPER_SHORTEST_PATH_EN
        guide1_d = ((state_d == PH_A) && !back_d) || ((state_d == PH_B) && back_d);
        guide2_d = ((state_d == PH_B) && !back_d) || ((state_d == PH_A) && back_d);
`else
        guide1_d = (state_d == PH_A);
        guide2_d = (state_d == PH_B);
`endif
    end

    // Reset re-synchronises the shadow with the tube's reset cathode 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            tgt_q    <= 10'd0;
            position <= 10'b0000000001;
            guide1   <= 1'b0;
            guide2   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef DEKATRON_STEPPER_SHORTEST_PATH_EN
            back_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            tgt_q    <= tgt_d;
            position <= pos_d;
            guide1   <= guide1_d;
            guide2   <= guide2_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
`ifdef DEKATRON_STEPPER_SHORTEST_PATH_EN
            back_q   <= back_d;
`endif
        end
    end

endmodule

// File: tb/tb_dekatron_stepper.sv
// Randomised self-checking bench for dekatron_stepper against a cycle-indexed transaction model.
module tb_dekatron_stepper;

    localparam int unsigned P = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       request;
    logic [9:0] target;
    logic       guide1, guide2, busy, done, error;
    logic [9:0] position;

    int n_checks = 0;
    int n_fail   = 0;
    int mpos     = 0;

    always #5 clk = ~clk;

    dekatron_stepper #(.PULSE_LEN(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .request  (request),
        .target   (target),
        .guide1   (guide1),
        .guide2   (guide2),
        .position (position),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (g1 g2 busy done err pos)", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] onehot(input int i);
        logic [9:0] v;
        v = 10'd1;
        return v << i;
    endfunction

    function automatic logic [31:0] observed();
        return 32'({guide1, guide2, busy, done, error, position});
    endfunction

    // mid_sel: 0 none, <0 random busy cycle, >0 that cycle. rst_k: cycle after which reset is asserted.
    task automatic run_req(input string tag, input logic [9:0] tgt, input int mid_sel, input int rst_k);
        int p, q, d, n, kind, last, kmax, s, cur, mid;
        logic back, g1, g2, bz, dn, er;
        logic [9:0] epos;
        p = mpos; q = p; n = 0; back = 1'b0; d = 0;
        if ($countones(tgt) != 1) begin
            kind = 0;
        end else begin
            for (int i = 0; i < 10; i++) if (tgt[i]) q = i;
            kind = (q == p) ? 1 : 2;
            d = (q - p + 10) % 10;
`ifdef DEKATRON_STEPPER_SHORTEST_PATH_EN
            back = (d > 5);
            n = back ? 10 - d : d;
`else
            n = d;
`endif
        end
        last = (kind == 2) ? 2 * int'(P) * n + 1 : 1;
        kmax = last + 1;
        mid  = mid_sel;
        if (mid_sel < 0) mid = (kind == 2) ? int'($urandom_range(1, last - 1)) : 0;

        @(negedge clk);
        request = 1'b1;
        target  = tgt;
        @(posedge clk);
        #1;
        for (int k = 1; k <= kmax; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            request = 1'b0;
            target  = 10'($urandom);
            g1 = 0; g2 = 0; bz = 0; dn = 0; er = 0;
            epos = onehot(p);
            if (kind == 0) begin
                er = (k == 1);
            end else if (kind == 1) begin
                dn = (k == 1);
            end else if (k < last) begin
                s    = (k - 1) / (2 * int'(P));
                cur  = back ? (p + 10 - s) % 10 : (p + s) % 10;
                epos = onehot(cur);
                bz   = 1'b1;
                g1   = (((k - 1) % (2 * int'(P))) < int'(P)) ^ back;
                g2   = ~g1;
            end else begin
                epos = onehot(q);
                dn   = (k == last);
            end
            check(tag, observed(), 32'({g1, g2, bz, dn, er, epos}));
            if (k == mid) begin
                request = 1'b1;
                target  = 10'($urandom);
            end
            if (rst_k != 0 && k == rst_k) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check({tag, "_rst"}, observed(), 32'({5'b0, 10'h001}));
                rst  = 1'b0;
                mpos = 0;
                return;
            end
        end
        if (kind == 2) mpos = q;
    endtask

    initial begin
        int r;
        logic [9:0] t;
        rst = 1'b1; request = 1'b0; target = 10'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset", observed(), 32'({5'b0, 10'h001}));

        run_req("fwd3",    10'h008, 0, 0);
        run_req("to1",     10'h002, 0, 0);
        run_req("zero",    10'h000, 0, 0);
        run_req("multi",   10'h011, 0, 0);
        run_req("same",    10'h002, 0, 0);
        run_req("to0",     10'h001, 0, 0);
        run_req("tie",     10'h020, 0, 0);
        run_req("midreq",  10'h200, 3, 0);
        run_req("rst_phb", 10'h004, 0, int'(P) + 1);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       t = onehot(int'($urandom_range(0, 9)));
            else if (r == 7) t = 10'd0;
            else             t = 10'($urandom);
            run_req("rand", t, ($urandom_range(0, 2) == 0) ? -1 : 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dekatron_stepper.md
Name: dekatron_stepper

Overview:
- Downstream consumer of the 4-bit BCD to one-hot position decoder.
- Takes a one-hot 10-position target and drives a dekatron's two guide phases (Guide1, Guide2) to move the glow step by step from its current position to the target.
- Keeps a shadow copy of the glow position and signals completion or an invalid request.
- Sits between the digit logic and the high-voltage guide drivers of one dekatron.

Parameters:
PULSE_LEN, 4, clock cycles each guide phase is held high (>=1)
CNT_W, $clog2(PULSE_LEN+1), width of the phase timer

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous, active-high reset
Request  input  1  start strobe, sampled only while idle
Target  input  10  one-hot target position; bit i = cathode i
Guide1  output  1  first guide phase drive
Guide2  output  1  second guide phase drive
Position  output  10  one-hot shadow of current glow position
Busy  output  1  high while stepping
Done  output  1  one-cycle pulse when the target is reached
Error  output  1  one-cycle pulse when the target is not one-hot

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: Position=10'b0000000001, Guide1=0, Guide2=0, Busy=0, Done=0, Error=0, FSM=IDLE, timer=0.
- FSM states:
  - IDLE: Busy=0, both guides 0.
  - PH_A: first phase of a step.
  - PH_B: second phase of a step.
  - FIN: one cycle, Done=1.
- Guide drive by direction:
  - Forward step: PH_A drives Guide1, PH_B drives Guide2.
  - Backward step: PH_A drives Guide2, PH_B drives Guide1.
  - Guides are registered outputs. Never both high in the same cycle.
- Request handling, when Request=1 in IDLE at edge t:
  - Target latched; stays stable for the whole operation.
  - Target zero or more than one bit set: Error=1 at cycle t+1, return to IDLE, Position unchanged, no guide activity.
  - Target == Position: Done=1 at t+1, no guide activity.
  - Otherwise: encode both positions to indices p and q, d=(q-p) mod 10. Direction forward if d<=5 (tie at 5 goes forward), else backward. Step count n = d (forward) or 10-d (backward).
- Step timing:
  - PH_A lasts PULSE_LEN cycles, then PH_B lasts PULSE_LEN cycles.
  - Position rotates on the edge that ends PH_B: forward = rotate left with bit9->bit0; backward = rotate right with bit0->bit9.
  - The next step's PH_A follows immediately, with no idle gap.
- Completion timing:
  - Busy=1 for cycles t+1 .. t+2*PULSE_LEN*n.
  - FIN (Done=1, Busy=0) at cycle t+2*PULSE_LEN*n+1. Position already equals Target in that cycle.
  - A new Request is accepted in the FIN cycle and handled as if in IDLE.
- Boundary conditions:
  - Request and Target are ignored while Busy.
  - Wrap-around 9<->0 is an ordinary step.
  - Rst mid-step: guides drop to 0 the next cycle and Position returns to index 0. The shadow deliberately re-synchronises with the tube's reset cathode.
  - Done and Error are never high together.

Optional Feature:
- Macro DEKATRON_STEPPER_SHORTEST_PATH_EN.
- Defined: bidirectional shortest-path stepping as described above.
- Undefined: direction is always forward and n=d (1..9). Guide2-first sequencing never occurs. Direction logic and right-rotate path are removed.

Test Plan:
- Rst held 2 cycles -> Position=10'h001, Guide1=Guide2=Busy=Done=Error=0.
- PULSE_LEN=2, Position=0, Request with Target=10'h008 at t:
  - Guide1 high t+1..t+2, Guide2 high t+3..t+4, pattern repeated 3 times.
  - Done at t+13; Position=10'h008.
- PULSE_LEN=2, Position=10'h008, Target=10'h002:
  - With macro: backward, 2 steps, Guide2 first; Done at t+9.
  - Without macro: forward 8 steps through 9->0 wrap; Done at t+33.
- Target=10'h000, then Target=10'h011 -> Error=1 at t+1 each time, no guide pulses, Position unchanged.
- Target equal to Position -> Done at t+1, Busy never high. Tie case Position=0, Target=10'h020 -> forward 5 steps.
- Request pulsed mid-step -> ignored, original completion time kept. Rst asserted during PH_B -> next cycle guides 0, Position=10'h001, Busy=0.
